// File: rtl/mmio_uart_tx_queue.sv
// MMIO transmit queue for the UART: CPU stores fill a FIFO and a drain FSM
// hands the bytes to the UART one start pulse at a time.
module mmio_uart_tx_queue #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mmio_wr_en,
   input  logic              mmio_rd_en,
   input  logic [3:0]        mmio_addr,
   input  logic [31:0]       mmio_wdata,
   output logic [31:0]       mmio_rdata,
   input  logic              UART_busy,
   output logic              mmio_uart_tx_start,
   output logic [DATA_W-1:0] mmio_uart_tx_data,
   output logic              fifo_full,
   output logic              fifo_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              overflow_q, overflow_d;
   logic              enable_q, enable_d;
   logic              tx_start_q, tx_start_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              wr_txdata_s, wr_status_s, wr_ctrl_s, flush_s;
   logic              go_s, pop_s, push_s, ovf_set_s, busy_fsm_s;
   logic              unused_s;

   assign wr_txdata_s = mmio_wr_en & (mmio_addr[3:2] == 2'd0);
   assign wr_status_s = mmio_wr_en & (mmio_addr[3:2] == 2'd1);
   assign wr_ctrl_s   = mmio_wr_en & (mmio_addr[3:2] == 2'd2);
   assign flush_s     = wr_ctrl_s & mmio_wdata[1];

   assign fifo_full  = (count_q == CW'(DEPTH));
   assign fifo_empty = (count_q == {CW{1'b0}});
   assign busy_fsm_s = (state_q != IDLE);

   // The pop happens on the IDLE->START edge, so a push into a full FIFO on that edge fits.
   assign go_s      = enable_q & ~fifo_empty & ~UART_busy;
   assign pop_s     = (state_q == IDLE) & go_s;
   assign push_s    = wr_txdata_s & ~flush_s & (~fifo_full | pop_s);
   assign ovf_set_s = wr_txdata_s & ~flush_s & fifo_full & ~pop_s;

   assign mmio_uart_tx_start = tx_start_q;
   assign mmio_uart_tx_data  = tx_data_q;
   assign unused_s           = ^{mmio_rd_en, mmio_addr[1:0], mmio_wdata[31:DATA_W]};

   // Register read mux
   always_comb begin
      mmio_rdata = 32'd0;
      case (mmio_addr[3:2])
         2'd1:    mmio_rdata = {16'd0, 8'(count_q), 4'd0, busy_fsm_s, overflow_q, fifo_empty, fifo_full};
         2'd2:    mmio_rdata = {31'd0, enable_q};
         default: mmio_rdata = 32'd0;
      endcase
   end

   // FIFO pointers, count and control bits
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_s) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
         else        wr_ptr_d = wr_ptr_q;
         if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
         else        rd_ptr_d = rd_ptr_q;
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      if (ovf_set_s)                       overflow_d = 1'b1;
      else if (wr_status_s & mmio_wdata[2]) overflow_d = 1'b0;
      else                                 overflow_d = overflow_q;
      if (wr_ctrl_s) enable_d = mmio_wdata[0];
      else           enable_d = enable_q;
   end

   // Drain FSM next state and registered UART outputs
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         IDLE: begin
            if (go_s) begin
               state_d    = START;
               tx_start_d = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q];
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            state_d = WAIT_BUSY;
            timer_d = {TW{1'b0}};
         end
         WAIT_BUSY: begin
            if (UART_busy)                               state_d = WAIT_DONE;
            else if (timer_q == TW'(BUSY_TIMEOUT - 1))   state_d = IDLE;
            else                                         timer_d = timer_q + TW'(1);
         end
         WAIT_DONE: begin
            if (!UART_busy) state_d = IDLE;
            else            state_d = WAIT_DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO storage; entries are only read when count says they are valid
   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_ptr_q] <= mmio_wdata[DATA_W-1:0];
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         timer_q    <= {TW{1'b0}};
         overflow_q <= 1'b0;
         enable_q   <= 1'b1;
         tx_start_q <= 1'b0;
         tx_data_q  <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx_queue.sv
// Scoreboard bench for mmio_uart_tx_queue: queued bytes are expected in order at tx_start.
module tb_mmio_uart_tx_queue;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        mmio_wr_en, mmio_rd_en;
   logic [3:0]  mmio_addr;
   logic [31:0] mmio_wdata, mmio_rdata;
   logic        uart_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        fifo_full, fifo_empty;

   logic        force_busy = 1'b0;
   logic        model_busy = 1'b0;
   logic        model_en   = 1'b0;
   logic        prev_start = 1'b0;
   int          busy_left  = 0;
   int          cyc        = 0;
   int          last_wr_cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  exp_q[$];
   int          pulse_cyc_q[$];

   assign uart_busy = force_busy | model_busy;

   mmio_uart_tx_queue #(.DATA_W(8), .DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .mmio_wr_en(mmio_wr_en), .mmio_rd_en(mmio_rd_en),
      .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
      .UART_busy(uart_busy), .mmio_uart_tx_start(tx_start), .mmio_uart_tx_data(tx_data),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Pulse monitor and scoreboard pop
   always @(negedge clk) begin
      if (reset) begin
         prev_start = 1'b0;
      end else begin
         if (tx_start) begin
            chk("no_back_to_back", {31'd0, prev_start}, 32'd0);
            pulse_cyc_q.push_back(cyc);
            chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
         end
         prev_start = tx_start;
      end
   end

   // UART model: busy for 10 cycles starting one cycle after each pulse
   always @(posedge clk) begin
      #1;
      if (reset) begin
         busy_left  = 0;
         model_busy = 1'b0;
      end else begin
         if (model_en && prev_start) busy_left = 10;
         if (busy_left > 0) begin
            model_busy = 1'b1;
            busy_left--;
         end else begin
            model_busy = 1'b0;
         end
      end
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      mmio_wr_en = 1'b1; mmio_addr = a; mmio_wdata = d; last_wr_cyc = cyc;
      @(posedge clk); #1;
      mmio_wr_en = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      mmio_rd_en = 1'b1; mmio_addr = a;
      @(negedge clk);
      d = mmio_rdata;
      mmio_rd_en = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      wr(4'h0, {24'd0, b});
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      logic [31:0] s;
      int n = 0;
      bit busy;
      do begin
         rd(4'h4, s);
         n++;
         busy = (exp_q.size() != 0) || s[3] || !s[1];
      end while (busy && n < budget);
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_pulses(input int cnt, input int budget, input string tag);
      int n = 0;
      while (pulse_cyc_q.size() < cnt && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, 32'(pulse_cyc_q.size() >= cnt), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] s;
      int fall_cyc;
      reset = 1'b1; mmio_wr_en = 1'b0; mmio_rd_en = 1'b0;
      mmio_addr = 4'h4; mmio_wdata = 32'd0;
      #12;
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_empty_full", {30'd0, fifo_empty, fifo_full}, 32'd2);
      chk("rst_status", mmio_rdata, 32'h0000_0002);
      @(posedge clk); #1 reset = 1'b0;
      rd(4'h8, s);  chk("rst_ctrl", s, 32'h0000_0001);
      wr(4'hC, 32'hFFFF_FFFF);
      rd(4'hC, s);  chk("addr3_reads_0", s, 32'd0);
      rd(4'h0, s);  chk("txdata_reads_0", s, 32'd0);

      // 1: single byte, UART never goes busy
      push(8'h41);
      wait_drain(40, "t1_drain");
      chk("t1_pulses", 32'(pulse_cyc_q.size()), 32'd1);
      if (pulse_cyc_q.size() == 1) chk("t1_latency", 32'(pulse_cyc_q[0] - last_wr_cyc), 32'd2);
      rd(4'h4, s);  chk("t1_status", s, 32'h0000_0002);

      // 2: three bytes against a UART busy for 10 cycles each
      pulse_cyc_q.delete();
      model_en = 1'b1;
      push(8'h48); push(8'h49); push(8'h21);
      wait_drain(200, "t2_drain");
      model_en = 1'b0;
      chk("t2_pulses", 32'(pulse_cyc_q.size()), 32'd3);
      if (pulse_cyc_q.size() == 3) begin
         chk("t2_gap1", 32'((pulse_cyc_q[1] - pulse_cyc_q[0]) >= 11), 32'd1);
         chk("t2_gap2", 32'((pulse_cyc_q[2] - pulse_cyc_q[1]) >= 11), 32'd1);
      end

      // 3: overfill with drain disabled, clear overflow, then drain
      wr(4'h8, 32'd0);
      for (int i = 0; i < DEPTH + 2; i++) push(8'h10 + 8'(i));
      rd(4'h4, s);  chk("t3_status_full", s, 32'h0000_1005);
      chk("t3_full_pin", {31'd0, fifo_full}, 32'd1);
      wr(4'h4, 32'h0000_0004);
      rd(4'h4, s);  chk("t3_ovf_cleared", s, 32'h0000_1001);
      pulse_cyc_q.delete();
      wr(4'h8, 32'h0000_0001);
      wait_drain(400, "t3_drain");
      chk("t3_pulses", 32'(pulse_cyc_q.size()), 32'(DEPTH));
      rd(4'h4, s);  chk("t3_status_end", s, 32'h0000_0002);

      // 4: UART busy blocks the start
      pulse_cyc_q.delete();
      force_busy = 1'b1;
      push(8'h55);
      repeat (8) @(posedge clk);
      chk("t4_no_pulse_busy", 32'(pulse_cyc_q.size()), 32'd0);
      rd(4'h4, s);  chk("t4_status_blocked", s, 32'h0000_0100);
      @(posedge clk); #1;
      force_busy = 1'b0; fall_cyc = cyc;
      wait_drain(40, "t4_drain");
      chk("t4_pulses", 32'(pulse_cyc_q.size()), 32'd1);
      if (pulse_cyc_q.size() == 1) chk("t4_latency", 32'(pulse_cyc_q[0] - fall_cyc), 32'd1);

      // 5: flush while byte 1 is in WAIT_DONE
      model_en = 1'b1;
      wr(4'h8, 32'd0);
      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      pulse_cyc_q.delete();
      wr(4'h8, 32'h0000_0001);
      wait_pulses(1, 20, "t5_first_pulse");
      repeat (2) @(posedge clk);
      wr(4'h8, 32'h0000_0003);
      exp_q.delete();
      repeat (30) @(posedge clk);
      chk("t5_pulses", 32'(pulse_cyc_q.size()), 32'd1);
      rd(4'h4, s);  chk("t5_status", s, 32'h0000_0002);
      rd(4'h8, s);  chk("t5_ctrl", s, 32'h0000_0001);

      // 6: reset during WAIT_DONE with three bytes queued
      wr(4'h8, 32'd0);
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      pulse_cyc_q.delete();
      wr(4'h8, 32'h0000_0001);
      wait_pulses(1, 20, "t6_first_pulse");
      rd(4'h4, s);  chk("t6_status_wait_done", s, 32'h0000_0308);
      #1;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("t6_rst_empty_full", {30'd0, fifo_empty, fifo_full}, 32'd2);
      chk("t6_rst_status", mmio_rdata, 32'h0000_0002);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      pulse_cyc_q.delete();
      repeat (30) @(posedge clk);
      chk("t6_no_pulse", 32'(pulse_cyc_q.size()), 32'd0);
      rd(4'h4, s);  chk("t6_status_after", s, 32'h0000_0002);
      model_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
